// File: rtl/dout_writer.sv
// dout_writer: transmit end of the ADC 4-line TDM serial link (8 channels, 2 words per line, MSB first)
//   clk_i/reset_i         : clock, synchronous active-high reset
//   ch1_i..ch8_i, tick_i  : channel samples, captured on the one-cycle tick strobe
//   dclk_o, drdy_o        : serial bit clock and frame marker (high for all of bit 0)
//   dout0_o..dout3_o      : serial data lines (ch1/ch2, ch3/ch4, ch5/ch6, ch7/ch8)
//   busy_o, done_o        : frame in progress, last-cycle-of-frame pulse
//   overrun_o             : pulse after a tick overwrote an unsent pending sample set
module dout_writer #(
  parameter int CLK_DIV  = 4,
  parameter int NUM_BITS = 24
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [NUM_BITS-1:0] ch1_i,
  input  logic [NUM_BITS-1:0] ch2_i,
  input  logic [NUM_BITS-1:0] ch3_i,
  input  logic [NUM_BITS-1:0] ch4_i,
  input  logic [NUM_BITS-1:0] ch5_i,
  input  logic [NUM_BITS-1:0] ch6_i,
  input  logic [NUM_BITS-1:0] ch7_i,
  input  logic [NUM_BITS-1:0] ch8_i,
  input  logic                tick_i,
  output logic                drdy_o,
  output logic                dclk_o,
  output logic                dout0_o,
  output logic                dout1_o,
  output logic                dout2_o,
  output logic                dout3_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                overrun_o
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  localparam int W  = 2 * NUM_BITS;
  localparam int PW = $clog2(2 * CLK_DIV);
  localparam int BW = $clog2(W);
  localparam logic [PW-1:0] PH_LAST  = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] PH_RISE  = PW'(CLK_DIV);
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);

  logic [0:0]                 state_q, state_d;
  logic [PW-1:0]              phase_q, phase_d;
  logic [BW-1:0]              bit_q, bit_d;
  logic [3:0][W-1:0]          sh_q, sh_d;
  logic [7:0][NUM_BITS-1:0]   ch, src, pend_q, pend_d;
  logic                       pend_v_q, pend_v_d, ovr_q, ovr_d;
  logic                       busy, wrap, last, load, pend_store;

  assign ch   = {ch8_i, ch7_i, ch6_i, ch5_i, ch4_i, ch3_i, ch2_i, ch1_i};
  assign busy = state_q == SHIFT;
  assign wrap = phase_q == PH_LAST;
  assign last = busy && wrap && bit_q == BIT_LAST;
  // A tick on the final cycle of a frame supersedes any older pending set and feeds the next frame directly.
  assign load       = (tick_i && (!busy || last)) || (last && pend_v_q);
  assign src        = tick_i ? ch : pend_q;
  assign pend_store = busy && !last && tick_i;

  always_comb begin
    state_d  = load ? SHIFT : (last ? IDLE : state_q);
    phase_d  = (load || !busy || wrap) ? '0 : phase_q + PW'(1);
    bit_d    = (load || !busy || last) ? '0 : (wrap ? bit_q + BW'(1) : bit_q);
    pend_d   = pend_store ? ch : pend_q;
    pend_v_d = pend_store || (pend_v_q && !last);
    ovr_d    = tick_i && busy && pend_v_q;
    for (int i = 0; i < 4; i++)
      sh_d[i] = load ? {src[2*i], src[2*i+1]} : ((busy && wrap) ? {sh_q[i][W-2:0], 1'b0} : sh_q[i]);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      ovr_q    <= ovr_d;
    end
  end

  assign busy_o    = busy;
  assign dclk_o    = busy && phase_q >= PH_RISE;
  assign drdy_o    = busy && bit_q == '0;
  assign dout0_o   = busy && sh_q[0][W-1];
  assign dout1_o   = busy && sh_q[1][W-1];
  assign dout2_o   = busy && sh_q[2][W-1];
  assign dout3_o   = busy && sh_q[3][W-1];
  assign done_o    = last;
  assign overrun_o = ovr_q;
endmodule

// File: tb/tb_dout_writer.sv
// tb_dout_writer: directed bench for dout_writer with an independent serial reader model
module tb_dout_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic tick2 = 1'b0;
  logic sel2 = 1'b0;
  logic [23:0] ch [8];
  logic busy1, dclk1, drdy1, done1, ovr1, busy2, dclk2, drdy2, done2, ovr2;
  logic [3:0] dout1, dout2;
  logic m_busy, m_dclk, m_drdy, m_done, m_ovr;
  logic [3:0] m_dout;

  logic [23:0] da [8] = '{24'h800001, 24'h7FFFFF, 24'h000000, 24'hFFFFFF, 24'h123456, 24'hABCDEF, 24'h000001, 24'h800000};
  logic [23:0] db [8] = '{24'h0F0F0F, 24'hF0F0F0, 24'h555555, 24'hAAAAAA, 24'h000002, 24'hFFFFFE, 24'h7FFFFE, 24'hC00003};
  logic [23:0] dc [8] = '{24'h13579B, 24'h2468AC, 24'hFEDCBA, 24'h987654, 24'h00FF00, 24'hFF00FF, 24'h3C3C3C, 24'hC3C3C3};
  logic [23:0] dd [8] = '{24'h111111, 24'h222222, 24'h333333, 24'h444444, 24'h555555, 24'h666666, 24'h777777, 24'h888888};

  int n_chk = 0, n_fail = 0;
  int cyc = 0, rises = 0, len = 0, cur_gap = 0, done_cyc = -1000;
  int n_done = 0, n_ovr = 0, busy_falls = 0;
  logic p_dclk = 1'b0, p_drdy = 1'b0, p_busy = 1'b0;
  logic [3:0][47:0] lines = '0;
  logic [3:0][47:0] fr_q [$];
  int len_q [$], rise_q [$], gap_q [$];

  always #5 clk = ~clk;

  dout_writer u_dut (
    .clk_i(clk), .reset_i(rst),
    .ch1_i(ch[0]), .ch2_i(ch[1]), .ch3_i(ch[2]), .ch4_i(ch[3]),
    .ch5_i(ch[4]), .ch6_i(ch[5]), .ch7_i(ch[6]), .ch8_i(ch[7]),
    .tick_i(tick), .drdy_o(drdy1), .dclk_o(dclk1),
    .dout0_o(dout1[0]), .dout1_o(dout1[1]), .dout2_o(dout1[2]), .dout3_o(dout1[3]),
    .busy_o(busy1), .done_o(done1), .overrun_o(ovr1)
  );

  dout_writer #(.CLK_DIV(2), .NUM_BITS(24)) u_dut2 (
    .clk_i(clk), .reset_i(rst),
    .ch1_i(ch[0]), .ch2_i(ch[1]), .ch3_i(ch[2]), .ch4_i(ch[3]),
    .ch5_i(ch[4]), .ch6_i(ch[5]), .ch7_i(ch[6]), .ch8_i(ch[7]),
    .tick_i(tick2), .drdy_o(drdy2), .dclk_o(dclk2),
    .dout0_o(dout2[0]), .dout1_o(dout2[1]), .dout2_o(dout2[2]), .dout3_o(dout2[3]),
    .busy_o(busy2), .done_o(done2), .overrun_o(ovr2)
  );

  assign m_busy = sel2 ? busy2 : busy1;
  assign m_dclk = sel2 ? dclk2 : dclk1;
  assign m_drdy = sel2 ? drdy2 : drdy1;
  assign m_done = sel2 ? done2 : done1;
  assign m_ovr  = sel2 ? ovr2  : ovr1;
  assign m_dout = sel2 ? dout2 : dout1;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reader model: samples each line on the dclk rising edge and delivers the words at done.
  initial forever begin
    @(negedge clk);
    if (m_dclk && !p_dclk) begin
      for (int l = 0; l < 4; l++) lines[l] = {lines[l][46:0], m_dout[l]};
      rises++;
    end
    if (m_drdy && !p_drdy) begin
      len = 1;
      rises = 0;
      cur_gap = cyc - done_cyc;
    end else len++;
    if (m_done) begin
      fr_q.push_back(lines);
      len_q.push_back(len);
      rise_q.push_back(rises);
      gap_q.push_back(cur_gap);
      n_done++;
      done_cyc = cyc;
    end
    if (m_ovr) n_ovr++;
    if (p_busy && !m_busy) busy_falls++;
    p_dclk = m_dclk;
    p_drdy = m_drdy;
    p_busy = m_busy;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_tick(input logic two, input logic [23:0] w [8]);
    ch = w;
    if (two) tick2 = 1'b1;
    else tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    tick2 = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (m_busy && t < 3000);
    check("idle_reached", 64'(m_busy), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(input string tag, input logic [23:0] w [8], input int exp_len, output int gap);
    logic [3:0][47:0] f;
    logic [47:0] ln;
    int t = 0;
    gap = 0;
    while (fr_q.size() == 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_seen"}, 64'(fr_q.size() > 0), 64'd1);
    if (fr_q.size() == 0) return;
    f = fr_q.pop_front();
    gap = gap_q.pop_front();
    check({tag, "_len"}, 64'(len_q.pop_front()), 64'(exp_len));
    check({tag, "_rises"}, 64'(rise_q.pop_front()), 64'd48);
    for (int k = 0; k < 8; k++) begin
      ln = f[k/2];
      check($sformatf("%s_ch%0d", tag, k + 1), 64'((k % 2 == 0) ? ln[47:24] : ln[23:0]), 64'(w[k]));
    end
  endtask

  initial begin
    int gap;
    ch = da;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy1), 64'd0);
    check("rst_dclk", 64'(dclk1), 64'd0);
    check("rst_drdy", 64'(drdy1), 64'd0);
    check("rst_dout", 64'(dout1), 64'd0);
    check("rst_done", 64'(done1), 64'd0);
    check("rst_ovr", 64'(ovr1), 64'd0);
    check("rst_busy2", 64'(busy2), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_cycles(2);

    n_done = 0;
    pulse_tick(1'b0, da);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check($sformatf("t_drdy_c%0d", c), 64'(drdy1), 64'(c <= 8));
      check($sformatf("t_dclk_c%0d", c), 64'(dclk1), 64'(c >= 5 && c <= 8));
      check($sformatf("t_dout0_c%0d", c), 64'(dout1[0]), 64'(c <= 8));
    end
    expect_frame("single", da, 384, gap);
    repeat (5) @(negedge clk);
    check("single_done_cnt", 64'(n_done), 64'd1);
    check("single_idle", 64'(busy1), 64'd0);
    wait_idle();

    n_ovr = 0;
    busy_falls = 0;
    pulse_tick(1'b0, da);
    wait_cycles(99);
    pulse_tick(1'b0, db);
    expect_frame("b2b_a", da, 384, gap);
    expect_frame("b2b_b", db, 384, gap);
    check("b2b_gap", 64'(gap), 64'd1);
    wait_idle();
    repeat (3) @(negedge clk);
    check("b2b_busy_falls", 64'(busy_falls), 64'd1);
    check("b2b_no_ovr", 64'(n_ovr), 64'd0);
    wait_cycles(1);

    n_ovr = 0;
    pulse_tick(1'b0, da);
    wait_cycles(49);
    pulse_tick(1'b0, db);
    wait_cycles(49);
    pulse_tick(1'b0, dc);
    expect_frame("ovr_a", da, 384, gap);
    expect_frame("ovr_c", dc, 384, gap);
    check("ovr_gap", 64'(gap), 64'd1);
    wait_idle();
    repeat (3) @(negedge clk);
    check("ovr_cnt", 64'(n_ovr), 64'd1);
    check("ovr_no_extra", 64'(fr_q.size()), 64'd0);
    wait_cycles(1);

    n_ovr = 0;
    pulse_tick(1'b0, dd);
    wait_cycles(383);
    pulse_tick(1'b0, db);
    expect_frame("last_d", dd, 384, gap);
    expect_frame("last_b", db, 384, gap);
    check("last_gap", 64'(gap), 64'd1);
    wait_idle();
    check("last_no_ovr", 64'(n_ovr), 64'd0);

    n_done = 0;
    pulse_tick(1'b0, dc);
    wait_cycles(160);
    rst = 1'b1;
    tick = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick = 1'b0;
    @(negedge clk);
    check("mrst_busy", 64'(busy1), 64'd0);
    check("mrst_dclk", 64'(dclk1), 64'd0);
    check("mrst_drdy", 64'(drdy1), 64'd0);
    check("mrst_dout", 64'(dout1), 64'd0);
    check("mrst_done", 64'(done1), 64'd0);
    check("mrst_ovr", 64'(ovr1), 64'd0);
    repeat (3) @(negedge clk);
    check("mrst_tick_ignored", 64'(busy1), 64'd0);
    check("mrst_no_done", 64'(n_done), 64'd0);
    @(posedge clk);
    #1;
    pulse_tick(1'b0, da);
    expect_frame("mrst_clean", da, 384, gap);
    wait_idle();

    sel2 = 1'b1;
    wait_cycles(2);
    n_done = 0;
    pulse_tick(1'b1, da);
    expect_frame("div2", da, 192, gap);
    repeat (5) @(negedge clk);
    check("div2_done_cnt", 64'(n_done), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
